// File: rtl/multi_dial_lock.sv
// multi_dial_lock: N-dial combination lock core.
// The active dial is stepped with right/left and committed with LOAD. After the
// last dial is committed, one CHECK cycle compares the entry against the
// combination register file. Repeated mismatches cause a timed lockout. The
// combination can be rewritten only while the lock is open.
//
// Command semantics: every input is a level that is sampled on each rising
// clock edge. There is no handshake. A command held for N cycles acts N times.
// Commands that do not apply to the current state are ignored.
module multi_dial_lock #(
  parameter int NUM_DIALS      = 3,
  parameter int WIDTH          = 5,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [NUM_DIALS*WIDTH-1:0] INIT_COMBO = {5'd3, 5'd30, 5'd24},
  localparam int SELW = (NUM_DIALS > 1) ? $clog2(NUM_DIALS) : 1,
  localparam int FW   = $clog2(MAX_FAIL + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_DIALS-1:0]       right,
  input  logic [NUM_DIALS-1:0]       left,
  input  logic                       LOAD,
  input  logic                       RELOCK,
  input  logic                       WR,
  input  logic [SELW-1:0]            regSel,
  input  logic [WIDTH-1:0]           wdata,
  output logic [NUM_DIALS*WIDTH-1:0] dial_val,
  output logic [SELW-1:0]            stage,
  output logic                       res,
  output logic                       fail,
  output logic                       locked_out,
  output logic [FW-1:0]              fail_cnt
);

  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [SELW-1:0] LAST_STAGE = SELW'(NUM_DIALS - 1);

  typedef enum logic [1:0] {
    ST_ENTER   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t           state_q;
  logic [SELW-1:0]  stage_q;
  logic [WIDTH-1:0] dial_q  [NUM_DIALS];
  logic [WIDTH-1:0] dial_d  [NUM_DIALS];
  logic [WIDTH-1:0] entry_q [NUM_DIALS];
  logic [WIDTH-1:0] combo_q [NUM_DIALS];
  logic [TW-1:0]    timer_q;
  logic             res_q;
  logic             fail_q;
  logic             locked_out_q;
  logic [FW-1:0]    fail_cnt_q;
  logic [FW-1:0]    fail_cnt_d;
  logic             match;

  // Next dial values: only the active dial moves. Opposing commands cancel out.
  always_comb begin
    for (int i = 0; i < NUM_DIALS; i++) begin
      dial_d[i] = dial_q[i];
      if (stage_q == SELW'(i)) begin
        if (right[i] && !left[i]) begin
          dial_d[i] = dial_q[i] + WIDTH'(1);
        end else if (left[i] && !right[i]) begin
          dial_d[i] = dial_q[i] - WIDTH'(1);
        end
      end
    end
  end

  // Full-entry comparison and the incremented mismatch count used by CHECK.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < NUM_DIALS; i++) begin
      if (entry_q[i] != combo_q[i]) begin
        match = 1'b0;
      end
    end
    fail_cnt_d = fail_cnt_q + FW'(1);
  end

  // Lock FSM together with its datapath registers. All outputs are registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_ENTER;
      stage_q      <= '0;
      timer_q      <= '0;
      res_q        <= 1'b0;
      fail_q       <= 1'b0;
      locked_out_q <= 1'b0;
      fail_cnt_q   <= '0;
      for (int i = 0; i < NUM_DIALS; i++) begin
        dial_q[i]  <= '0;
        entry_q[i] <= '0;
        combo_q[i] <= INIT_COMBO[i*WIDTH +: WIDTH];
      end
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        ST_ENTER: begin
          if (RELOCK) begin
            stage_q <= '0;
            for (int i = 0; i < NUM_DIALS; i++) dial_q[i] <= '0;
          end else begin
            for (int i = 0; i < NUM_DIALS; i++) dial_q[i] <= dial_d[i];
            if (LOAD) begin
              // Commit the value the dial held before this edge's step.
              for (int i = 0; i < NUM_DIALS; i++) begin
                if (stage_q == SELW'(i)) entry_q[i] <= dial_q[i];
              end
              if (stage_q == LAST_STAGE) begin
                state_q <= ST_CHECK;
              end else begin
                stage_q <= stage_q + SELW'(1);
              end
            end
          end
        end
        ST_CHECK: begin
          if (match) begin
            state_q    <= ST_OPEN;
            res_q      <= 1'b1;
            fail_cnt_q <= '0;
          end else begin
            fail_q     <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == FW'(MAX_FAIL)) begin
              state_q      <= ST_LOCKOUT;
              timer_q      <= TW'(LOCKOUT_CYCLES);
              locked_out_q <= 1'b1;
            end else begin
              state_q <= ST_ENTER;
              stage_q <= '0;
              for (int i = 0; i < NUM_DIALS; i++) dial_q[i] <= '0;
            end
          end
        end
        ST_OPEN: begin
          if (RELOCK) begin
            // RELOCK takes priority, so a write issued in the same cycle is dropped.
            state_q <= ST_ENTER;
            res_q   <= 1'b0;
            stage_q <= '0;
            for (int i = 0; i < NUM_DIALS; i++) dial_q[i] <= '0;
          end else if (WR) begin
            // An out-of-range regSel matches no entry, so the write is a no-op.
            for (int i = 0; i < NUM_DIALS; i++) begin
              if (regSel == SELW'(i)) combo_q[i] <= wdata;
            end
          end
        end
        ST_LOCKOUT: begin
          // The timer holds LOCKOUT_CYCLES on entry, so the exit at a count of 1
          // gives exactly LOCKOUT_CYCLES cycles in this state.
          if (timer_q == TW'(1)) begin
            state_q      <= ST_ENTER;
            timer_q      <= '0;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
            stage_q      <= '0;
            for (int i = 0; i < NUM_DIALS; i++) dial_q[i] <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= ST_ENTER;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIALS; g++) begin : g_pack
    assign dial_val[g*WIDTH +: WIDTH] = dial_q[g];
  end

  assign stage      = stage_q;
  assign res        = res_q;
  assign fail       = fail_q;
  assign locked_out = locked_out_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_multi_dial_lock.sv
// tb_multi_dial_lock: directed test of the default 3-dial, 5-bit lock.
// The combination at reset is 24,30,3 (dial 0 first).
module tb_multi_dial_lock;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  right, left;
  logic        LOAD, RELOCK, WR;
  logic [1:0]  regSel;
  logic [4:0]  wdata;
  logic [14:0] dial_val;
  logic [1:0]  stage;
  logic        res, fail, locked_out;
  logic [1:0]  fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  multi_dial_lock dut (
    .CLK(CLK), .RST(RST), .right(right), .left(left), .LOAD(LOAD),
    .RELOCK(RELOCK), .WR(WR), .regSel(regSel), .wdata(wdata),
    .dial_val(dial_val), .stage(stage), .res(res), .fail(fail),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge. Outputs are
  // sampled at the same point.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    right = '0; left = '0; LOAD = 0; RELOCK = 0; WR = 0; regSel = '0; wdata = '0;
  endtask

  task automatic turn(input int d, input bit up, input int n);
    for (int k = 0; k < n; k++) begin
      right = '0; left = '0;
      right[d] = up; left[d] = !up;
      cycle();
    end
    right = '0; left = '0;
  endtask

  task automatic load();
    LOAD = 1; cycle(); LOAD = 0;
  endtask

  task automatic relock();
    RELOCK = 1; cycle(); RELOCK = 0;
  endtask

  // Enter a full combination with right steps from 0. Afterwards the bench is
  // one edge past CHECK, so the result is visible on the outputs.
  task automatic enter3(input int a, input int b, input int c);
    turn(0, 1'b1, a); load();
    turn(1, 1'b1, b); load();
    turn(2, 1'b1, c); load();
    cycle();
  endtask

  task automatic wrong_entry();
    load(); load(); load();
    cycle();
  endtask

  int cnt;
  int iter;

  initial begin
    RST = 1'b0;
    idle_inputs();

    // T1 reset
    repeat (2) @(posedge CLK);
    #1;
    check("rst_res", res, 0);
    check("rst_fail", fail, 0);
    check("rst_locked_out", locked_out, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_stage", stage, 0);
    check("rst_dial_val", dial_val, 0);
    RST = 1'b1;
    cycle();

    // T2 correct entry
    turn(0, 1'b1, 24);
    check("t2_dial0", dial_val, 15'd24);
    load();
    check("t2_stage1", stage, 1);
    turn(1, 1'b0, 1);
    check("t2_dial1_wrap", dial_val[9:5], 31);
    turn(1, 1'b0, 1);
    check("t2_dial1", dial_val[9:5], 30);
    load();
    check("t2_stage2", stage, 2);
    turn(2, 1'b1, 3);
    load();
    check("t2_check_res", res, 0);
    check("t2_check_fail", fail, 0);
    cycle();
    check("t2_open_res", res, 1);
    check("t2_open_fail", fail, 0);
    check("t2_open_fail_cnt", fail_cnt, 0);
    cycle();
    check("t2_no_fail", fail, 0);

    // T3 lockout
    relock();
    check("t3_relock_res", res, 0);
    check("t3_relock_dials", dial_val, 0);
    check("t3_relock_stage", stage, 0);
    for (int k = 1; k <= 3; k++) begin
      wrong_entry();
      check($sformatf("t3_fail_%0d", k), fail, 1);
      check($sformatf("t3_fail_cnt_%0d", k), fail_cnt, k);
      if (k < 3) begin
        cycle();
        check($sformatf("t3_fail_drop_%0d", k), fail, 0);
        check($sformatf("t3_not_locked_%0d", k), locked_out, 0);
      end
    end
    cnt = 0;
    iter = 0;
    while (locked_out === 1'b1 && iter < 40) begin
      cnt++;
      right = 3'b001; left = 3'b010; LOAD = iter[0];
      cycle();
      iter++;
    end
    idle_inputs();
    check("t3_lockout_len", cnt, 16);
    check("t3_after_locked", locked_out, 0);
    check("t3_after_fail_cnt", fail_cnt, 0);
    check("t3_after_stage", stage, 0);
    check("t3_after_dials", dial_val, 0);

    // T4 reprogram
    enter3(24, 30, 3);
    check("t4_open", res, 1);
    WR = 1; regSel = 2'd1; wdata = 5'd7; cycle();
    regSel = 2'd3; wdata = 5'd0; cycle();
    RELOCK = 1; regSel = 2'd0; wdata = 5'd1; cycle();
    idle_inputs();
    check("t4_closed", res, 0);
    enter3(24, 30, 3);
    check("t4_old_fail", fail, 1);
    check("t4_old_res", res, 0);
    check("t4_old_fail_cnt", fail_cnt, 1);
    cycle();
    enter3(24, 7, 3);
    check("t4_new_res", res, 1);
    check("t4_new_fail", fail, 0);
    check("t4_new_fail_cnt", fail_cnt, 0);
    relock();

    // T5 step rules
    turn(0, 1'b0, 1);
    check("t5_wrap_down", dial_val[4:0], 31);
    turn(0, 1'b1, 1);
    check("t5_wrap_up", dial_val[4:0], 0);
    turn(0, 1'b1, 23);
    right = 3'b001; left = 3'b001; cycle(); cycle();
    idle_inputs();
    check("t5_both_hold", dial_val, 15'd23);
    right = 3'b010; left = 3'b100; cycle(); cycle(); cycle();
    idle_inputs();
    check("t5_inactive_hold", dial_val, 15'd23);
    right = 3'b001; LOAD = 1; cycle();
    idle_inputs();
    check("t5_load_step_stage", stage, 1);
    check("t5_load_step_dial", dial_val[4:0], 24);
    turn(1, 1'b1, 7); load();
    turn(2, 1'b1, 3); load();
    cycle();
    check("t5_prestep_commit_fail", fail, 1);
    check("t5_prestep_commit_res", res, 0);
    check("t5_prestep_fail_cnt", fail_cnt, 1);

    // T6 async reset mid-entry
    turn(0, 1'b1, 24); load();
    turn(1, 1'b0, 2); load();
    turn(2, 1'b1, 1);
    check("t6_pre_stage", stage, 2);
    #2 RST = 1'b0;
    #1;
    check("t6_entry_stage", stage, 0);
    check("t6_entry_dials", dial_val, 0);
    check("t6_entry_fail_cnt", fail_cnt, 0);
    check("t6_entry_res", res, 0);
    #1 RST = 1'b1;
    enter3(24, 30, 3);
    check("t6_combo_restored", res, 1);
    relock();

    // T6 async reset mid-lockout
    wrong_entry(); cycle();
    wrong_entry(); cycle();
    wrong_entry();
    repeat (5) cycle();
    check("t6_in_lockout", locked_out, 1);
    #2 RST = 1'b0;
    #1;
    check("t6_lock_locked_out", locked_out, 0);
    check("t6_lock_fail_cnt", fail_cnt, 0);
    check("t6_lock_fail", fail, 0);
    check("t6_lock_stage", stage, 0);
    #1 RST = 1'b1;
    enter3(24, 30, 3);
    check("t6_lock_reopen", res, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
